// File: rtl/shared_wb_arbiter_if.sv
// Bus bundle between the rv_core master slots, the arbiter and the shared
// peripheral interconnect.
//   m_*  : per-master slot signals, flattened (slot k at [W*k +: W])
//   s_*  : single shared slave-side port
// Modports:
//   slave  : the arbiter's view (it serves the masters, drives the slave bus)
//   master : the environment's view (cores drive m_*_i, peripheral drives s_*_i)
interface shared_wb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0]    m_cyc_i;
  logic [NUM_MASTERS-1:0]    m_stb_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [4*NUM_MASTERS-1:0]  m_sel_i;
  logic [32*NUM_MASTERS-1:0] m_adr_i;
  logic [32*NUM_MASTERS-1:0] m_dat_i;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic [NUM_MASTERS-1:0]    m_err_o;
  logic [31:0]               m_dat_o;
  logic                      s_cyc_o;
  logic                      s_stb_o;
  logic                      s_we_o;
  logic [3:0]                s_sel_o;
  logic [31:0]               s_adr_o;
  logic [31:0]               s_dat_o;
  logic                      s_ack_i;
  logic [31:0]               s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
endinterface

// File: rtl/shared_wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS core slots share one peripheral bus.
// A watchdog ends any strobe the slave leaves unacked for TIMEOUT_CYCLES cycles,
// answering the owner with err and freeing the bus (TIMEOUT_CYCLES=0 disables it).
// Ports:
//   wb_clk_i  : bus clock
//   wb_resetb : asynchronous active-low reset
//   bus       : slot and slave signals (shared_wb_arbiter_if.slave)
//   grant_o   : one-hot registered owner
//   timeout_o : one-cycle pulse while the err response is returned
module shared_wb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_resetb,
  shared_wb_arbiter_if.slave     bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);
  localparam int IW  = $clog2(NUM_MASTERS);
  localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [WDW-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t                  state, state_nx;
  logic [IW-1:0]           owner, owner_nx;
  logic [IW-1:0]           rr_ptr, rr_ptr_nx;
  logic [NUM_MASTERS-1:0]  grant_nx;
  logic [WDW-1:0]          wdog, wdog_nx;
  logic [IW-1:0]           pick;
  logic                    pick_vld;
  logic                    own_cyc, fire, stall;
  logic [IW-1:0]           rr_after;

  // Packed per-slot views of the flattened buses
  logic [NUM_MASTERS-1:0][3:0]  sel_v;
  logic [NUM_MASTERS-1:0][31:0] adr_v, dat_v;
  assign sel_v = bus.m_sel_i;
  assign adr_v = bus.m_adr_i;
  assign dat_v = bus.m_dat_i;

  // Cyclic search from rr_ptr; iterating downwards lets the smallest offset win.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (bus.m_cyc_i[IW'((int'(rr_ptr) + i) % NUM_MASTERS)]) begin
        pick     = IW'((int'(rr_ptr) + i) % NUM_MASTERS);
        pick_vld = 1'b1;
      end
    end
  end

  // Slave bus is a pure mux of the owner slot; the owner's cyc is passed straight
  // through so an abort drops s_cyc_o in the same cycle.
  always_comb begin
    own_cyc     = bus.m_cyc_i[owner];
    bus.s_cyc_o = (state == BUSY) & own_cyc;
    bus.s_stb_o = (state == BUSY) & own_cyc & bus.m_stb_i[owner];
    bus.s_we_o  = (state == BUSY) & bus.m_we_i[owner];
    bus.s_sel_o = sel_v[owner];
    bus.s_adr_o = adr_v[owner];
    bus.s_dat_o = dat_v[owner];
    bus.m_dat_o = bus.s_dat_i;

    stall = bus.s_stb_o & ~bus.s_ack_i;
    // An ack in the last allowed cycle beats the watchdog.
    fire  = (TIMEOUT_CYCLES != 0) && stall && (wdog == WD_LAST);

    bus.m_ack_o        = '0;
    bus.m_ack_o[owner] = bus.s_stb_o & bus.s_ack_i;
    bus.m_err_o        = '0;
    bus.m_err_o[owner] = (state == ERR);
    timeout_o          = (state == ERR);
  end

  assign rr_after = IW'((int'(owner) + 1) % NUM_MASTERS);

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    rr_ptr_nx = rr_ptr;
    grant_nx  = grant_o;
    wdog_nx   = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          owner_nx       = pick;
          grant_nx       = '0;
          grant_nx[pick] = 1'b1;
          state_nx       = BUSY;
        end
      end
      BUSY: begin
        if (fire) begin
          state_nx = ERR;
        end else if (!own_cyc) begin
          state_nx  = IDLE;
          grant_nx  = '0;
          rr_ptr_nx = rr_after;
        end else if (stall) begin
          wdog_nx = (wdog == WD_MAX) ? wdog : wdog + 1'b1;
        end
      end
      ERR: begin
        state_nx  = IDLE;
        grant_nx  = '0;
        rr_ptr_nx = rr_after;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_resetb) begin
    if (!wb_resetb) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      grant_o <= '0;
      wdog    <= '0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      rr_ptr  <= rr_ptr_nx;
      grant_o <= grant_nx;
      wdog    <= wdog_nx;
    end
  end
endmodule

// File: tb/tb_shared_wb_arbiter.sv
module tb_shared_wb_arbiter;
  localparam int N = 4;
  localparam logic [31:0] RD_KEY = 32'h5A5A_5A5A;

  typedef struct {
    int          k;
    bit          is_err;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  logic         clk;
  logic         rstn;
  logic [N-1:0] grant;
  logic         tmo;
  int           n_pass;
  int           n_total;
  int           slave_lat;
  exp_t         sb[$];
  logic [N-1:0] glog[$];

  shared_wb_arbiter_if #(.NUM_MASTERS(N)) bus ();

  shared_wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i (clk),
    .wb_resetb(rstn),
    .bus      (bus),
    .grant_o  (grant),
    .timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: acks the slave_lat-th cycle after a strobe starts (-1 = never);
  // read data is the address scrambled with RD_KEY.
  initial begin
    int cnt;
    cnt = 0;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.s_stb_o && slave_lat >= 0) begin
        if (cnt == slave_lat) begin
          bus.s_ack_i = 1'b1;
          cnt = 0;
        end else begin
          bus.s_ack_i = 1'b0;
          cnt++;
        end
      end else begin
        bus.s_ack_i = 1'b0;
        cnt = 0;
      end
      bus.s_dat_i = bus.s_adr_o ^ RD_KEY;
    end
  end

  // Grant history: one entry per change of grant_o.
  initial begin
    logic [N-1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (grant !== prev) begin
        glog.push_back(grant);
        prev = grant;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want done");
    $fatal(1, "timeout");
  end

  // One transfer on slot k; the ack/err it receives is checked against the
  // front of the scoreboard. cyc_n = strobe cycles seen while owning the bus.
  task automatic master_xfer(input int k, input bit we, input logic [31:0] adr,
                             input logic [31:0] dat, output int cyc_n);
    exp_t        e;
    bit          done;
    logic [3:0]  oh;
    done  = 0;
    cyc_n = 0;
    oh    = 4'b0001 << k;
    @(posedge clk);
    #1;
    bus.m_cyc_i[k] = 1'b1;
    bus.m_stb_i[k] = 1'b1;
    bus.m_we_i[k]  = we;
    bus.m_sel_i[4*k +: 4]  = 4'hF;
    bus.m_adr_i[32*k +: 32] = adr;
    bus.m_dat_i[32*k +: 32] = dat;
    for (int t = 0; t < 80 && !done; t++) begin
      @(negedge clk);
      if (grant[k] && bus.s_stb_o) cyc_n++;
      if (bus.m_ack_o[k] || bus.m_err_o[k]) begin
        done = 1;
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected m%0d: ack=%b err=%b, want no response", k, bus.m_ack_o, bus.m_err_o);
        end else begin
          e = sb.pop_front();
          if (e.k != k || grant !== oh || tmo !== e.is_err
              || bus.m_ack_o !== (e.is_err ? 4'b0 : oh)
              || bus.m_err_o !== (e.is_err ? oh : 4'b0)
              || (e.is_err && bus.s_cyc_o !== 1'b0))
            $display("FAIL sb_ctl m%0d: grant=%b ack=%b err=%b tmo=%b scyc=%b, want m%0d err=%0b",
                     k, grant, bus.m_ack_o, bus.m_err_o, tmo, bus.s_cyc_o, e.k, e.is_err);
          else n_pass++;
          if (!e.is_err) begin
            n_total++;
            if (bus.s_adr_o !== e.adr || bus.s_we_o !== e.we || bus.s_sel_o !== 4'hF
                || (e.we ? bus.s_dat_o : bus.m_dat_o) !== e.dat)
              $display("FAIL sb_data m%0d: adr=%h we=%b sel=%h wdat=%h rdat=%h, want adr=%h we=%b dat=%h",
                       k, bus.s_adr_o, bus.s_we_o, bus.s_sel_o, bus.s_dat_o, bus.m_dat_o, e.adr, e.we, e.dat);
            else n_pass++;
          end
        end
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL xfer_wait m%0d: no ack/err within bound, want response", k);
    end
    @(posedge clk);
    #1;
    bus.m_cyc_i[k] = 1'b0;
    bus.m_stb_i[k] = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.m_cyc_i = '1;
    bus.m_stb_i = '1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, grant, bus.m_ack_o, bus.m_err_o, tmo} !== '0)
      $display("FAIL reset_held: cyc=%b stb=%b we=%b grant=%b ack=%b err=%b tmo=%b, want all 0",
               bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, grant, bus.m_ack_o, bus.m_err_o, tmo);
    else n_pass++;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (grant !== '0 || bus.s_cyc_o !== 1'b0)
      $display("FAIL reset_idle: grant=%b cyc=%b, want 0000 0", grant, bus.s_cyc_o);
    else n_pass++;
  endtask

  task automatic test_single_write();
    int n, ack_n;
    logic [3:0] ack_v;
    slave_lat = 2;
    sb.push_back('{k:0, is_err:0, we:1, adr:32'h3000_0010, dat:32'hDEAD_BEEF});
    ack_n = 0;
    ack_v = '0;
    fork
      master_xfer(0, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, n);
      begin
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (bus.s_cyc_o !== 1'b0 || bus.m_cyc_i[0] !== 1'b1)
          $display("FAIL grant_latency_pre: scyc=%b mcyc=%b, want 0 1", bus.s_cyc_o, bus.m_cyc_i[0]);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1 || bus.s_adr_o !== 32'h3000_0010
            || bus.s_dat_o !== 32'hDEAD_BEEF || bus.s_sel_o !== 4'hF || bus.s_we_o !== 1'b1)
          $display("FAIL grant_latency_post: cyc=%b stb=%b adr=%h dat=%h sel=%h we=%b, want M0 fields",
                   bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o);
        else n_pass++;
        repeat (8) begin
          @(negedge clk);
          if (bus.m_ack_o !== '0) begin
            ack_n++;
            ack_v = bus.m_ack_o;
          end
        end
      end
    join
    n_total++;
    if (ack_n != 1 || ack_v !== 4'b0001 || n != 3)
      $display("FAIL single_ack: ack_cycles=%0d ack=%b stb_cycles=%0d, want 1 0001 3", ack_n, ack_v, n);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int n0, n1, n2, n3, g0;
    logic [N-1:0] want[8];
    want = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    slave_lat = 2;
    for (int k = 0; k < N; k++)
      sb.push_back('{k:k, is_err:0, we:1, adr:32'h1000_0000 + 32'(k * 16), dat:32'hA000_0000 + 32'(k)});
    g0 = glog.size();
    fork
      master_xfer(0, 1'b1, 32'h1000_0000, 32'hA000_0000, n0);
      master_xfer(1, 1'b1, 32'h1000_0010, 32'hA000_0001, n1);
      master_xfer(2, 1'b1, 32'h1000_0020, 32'hA000_0002, n2);
      master_xfer(3, 1'b1, 32'h1000_0030, 32'hA000_0003, n3);
    join
    repeat (3) @(negedge clk);
    n_total++;
    if (glog.size() - g0 != 8) begin
      $display("FAIL rr_seq_len: %0d grant changes, want 8", glog.size() - g0);
    end else begin
      bit ok;
      ok = 1;
      for (int i = 0; i < 8; i++) if (glog[g0 + i] !== want[i]) ok = 0;
      if (!ok) $display("FAIL rr_seq: %b %b %b %b %b %b %b %b, want 0001 0000 0010 0000 0100 0000 1000 0000",
                        glog[g0], glog[g0+1], glog[g0+2], glog[g0+3], glog[g0+4], glog[g0+5], glog[g0+6], glog[g0+7]);
      else n_pass++;
    end
  endtask

  task automatic test_rr_pointer();
    int n1, n2, n3, g0;
    logic [N-1:0] want[6];
    want = '{4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000};
    slave_lat = 2;
    sb.push_back('{k:2, is_err:0, we:1, adr:32'h2000_0040, dat:32'h1234_5678});
    sb.push_back('{k:3, is_err:0, we:1, adr:32'h2000_0080, dat:32'hCAFE_0003});
    sb.push_back('{k:1, is_err:0, we:0, adr:32'h2000_00C4, dat:32'h2000_00C4 ^ RD_KEY});
    g0 = glog.size();
    fork
      master_xfer(2, 1'b1, 32'h2000_0040, 32'h1234_5678, n2);
      begin repeat (2) @(posedge clk); master_xfer(1, 1'b0, 32'h2000_00C4, 32'h0, n1); end
      begin repeat (2) @(posedge clk); master_xfer(3, 1'b1, 32'h2000_0080, 32'hCAFE_0003, n3); end
    join
    repeat (3) @(negedge clk);
    n_total++;
    if (glog.size() - g0 != 6) begin
      $display("FAIL rr_ptr_len: %0d grant changes, want 6", glog.size() - g0);
    end else begin
      bit ok;
      ok = 1;
      for (int i = 0; i < 6; i++) if (glog[g0 + i] !== want[i]) ok = 0;
      if (!ok) $display("FAIL rr_ptr_seq: %b %b %b %b %b %b, want 0100 0000 1000 0000 0010 0000",
                        glog[g0], glog[g0+1], glog[g0+2], glog[g0+3], glog[g0+4], glog[g0+5]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int n;
    slave_lat = -1;
    sb.push_back('{k:1, is_err:1, we:0, adr:32'h4000_0000, dat:32'h0});
    master_xfer(1, 1'b0, 32'h4000_0000, 32'h0, n);
    n_total++;
    if (n != 8) $display("FAIL timeout_cycles: err after %0d stb cycles, want 8", n);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (grant !== '0 || tmo !== 1'b0 || bus.m_err_o !== '0 || bus.s_cyc_o !== 1'b0)
      $display("FAIL timeout_after: grant=%b tmo=%b err=%b cyc=%b, want 0000 0 0000 0",
               grant, tmo, bus.m_err_o, bus.s_cyc_o);
    else n_pass++;
  endtask

  task automatic test_ack_beats_timeout();
    int n;
    slave_lat = 7;
    sb.push_back('{k:1, is_err:0, we:0, adr:32'h4000_0100, dat:32'h4000_0100 ^ RD_KEY});
    master_xfer(1, 1'b0, 32'h4000_0100, 32'h0, n);
    n_total++;
    if (n != 8) $display("FAIL late_ack_cycles: ack after %0d stb cycles, want 8", n);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_busy();
    slave_lat = 0;
    sb.push_back('{k:0, is_err:0, we:1, adr:32'h3000_0020, dat:32'h0BAD_F00D});
    @(posedge clk);
    #1;
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    bus.m_we_i[0]  = 1'b1;
    bus.m_sel_i[3:0]  = 4'hF;
    bus.m_adr_i[31:0] = 32'h3000_0020;
    bus.m_dat_i[31:0] = 32'h0BAD_F00D;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (bus.s_cyc_o !== 1'b1 || bus.m_ack_o !== 4'b0001 || grant !== 4'b0001)
      $display("FAIL busy_before_reset: cyc=%b ack=%b grant=%b, want 1 0001 0001",
               bus.s_cyc_o, bus.m_ack_o, grant);
    else n_pass++;
    if (sb.size() != 0) void'(sb.pop_front());
    #2;
    rstn = 1'b0;
    #1;
    n_total++;
    if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || grant !== '0 || bus.m_ack_o !== '0)
      $display("FAIL async_reset: cyc=%b stb=%b grant=%b ack=%b, want 0 0 0000 0000",
               bus.s_cyc_o, bus.s_stb_o, grant, bus.m_ack_o);
    else n_pass++;
    bus.m_cyc_i = '1;
    bus.m_stb_i = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_total++;
    if (grant !== 4'b0001) $display("FAIL reset_first_grant: grant=%b, want 0001", grant);
    else n_pass++;
    bus.m_cyc_i = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    slave_lat = 2;
    rstn = 1'b0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_sel_i = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_rr_pointer();
    test_timeout();
    test_ack_beats_timeout();
    test_reset_busy();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_leftover: %0d expected responses never seen, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
